// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES SPI front-end: FSM states, direction codes, frame length.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_IN,
        WAIT_CORE,
        SHIFT_OUT
    } state_t;

    localparam logic [7:0] DIR_ENC = 8'h00;
    localparam logic [7:0] DIR_DEC = 8'hFF;

    // Serial frame length: key + block, plus a leading direction byte when runtime-selected.
    function automatic int total_bits(input int k, input int inv);
        return k + 128 + ((inv == 2) ? 8 : 0);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle rise/fall pulses.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    // [0],[1] synchronise; [2] holds the previous synced level for edge detection
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave front-end of the AES core: frame deserialiser, start pulse, result serialiser.
// Optional AES_SPI_FRAMECHK_EN adds frame_err and rejects malformed frames.
module aes_spi_frontend
    import aes_pkg::*;
#(
    parameter int K   = 128,
    parameter int INV = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sck,
    input  logic           sdi,
    input  logic           load,
    output logic           sdo,
    output logic           done,
    output logic           core_start,
    output logic           core_dir,
    output logic [127:0]   core_in,
    output logic [K-1:0]   core_key,
    input  logic [127:0]   core_out,
    input  logic           core_done
`ifdef AES_SPI_FRAMECHK_EN
    ,
    output logic           frame_err
`endif
);

    localparam int TOTAL = total_bits(K, INV);
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

    state_t           state_q, state_d;
    logic [TOTAL-1:0] sr_q, sr_d, sr_shift;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_shift;
    logic [127:0]     out_q, out_d;
    logic [6:0]       ocnt_q, ocnt_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic             dir_q, dir_d;
    logic [127:0]     in_q, in_d;
    logic [K-1:0]     key_q, key_d;
    logic             sck_rise, sck_fall_unused, load_rise, load_fall;
    logic [7:0]       dir_byte;
    logic             dir_sel;
    logic             frame_bad;

    sync_edge u_sck_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall_unused)
    );

    sync_edge u_load_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (load),
        .rise_o (load_rise),
        .fall_o (load_fall)
    );

    // The latch on load falling sees the frame including a same-cycle sck shift.
    assign sr_shift  = sck_rise ? {sr_q[TOTAL-2:0], sdi} : sr_q;
    assign cnt_shift = (sck_rise && (cnt_q != TOTAL_C)) ? cnt_q + 1'b1 : cnt_q;
    assign dir_byte  = sr_shift[TOTAL-1 -: 8];
    assign dir_sel   = (INV == 0) ? 1'b0 :
                       (INV == 1) ? 1'b1 : (dir_byte == DIR_DEC);

`ifdef AES_SPI_FRAMECHK_EN
    logic err_q, err_d;
    assign frame_bad = (cnt_shift != TOTAL_C) ||
                       ((INV == 2) && (dir_byte != DIR_ENC) && (dir_byte != DIR_DEC));
    assign frame_err = err_q;
`else
    assign frame_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (load_rise) state_d = SHIFT_IN;
            SHIFT_IN:  if (load_fall) state_d = frame_bad ? IDLE : WAIT_CORE;
            WAIT_CORE: if (core_done) state_d = SHIFT_OUT;
            SHIFT_OUT: begin
                if (load_rise) begin
                    state_d = SHIFT_IN;
                end else if (sck_rise && (ocnt_q == 7'd127)) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ocnt_d  = ocnt_q;
        done_d  = done_q;
        start_d = 1'b0;
        dir_d   = dir_q;
        in_d    = in_q;
        key_d   = key_q;
`ifdef AES_SPI_FRAMECHK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load_rise) begin
                    sr_d   = '0;
                    cnt_d  = '0;
                    done_d = 1'b0;
                end
            end
            SHIFT_IN: begin
                sr_d  = sr_shift;
                cnt_d = cnt_shift;
                if (load_fall) begin
                    if (frame_bad) begin
`ifdef AES_SPI_FRAMECHK_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        key_d   = sr_shift[K-1:0];
                        in_d    = sr_shift[K+127:K];
                        dir_d   = dir_sel;
                        start_d = 1'b1;
                    end
                end
            end
            WAIT_CORE: begin
                if (core_done) begin
                    out_d  = core_out;
                    ocnt_d = '0;
                    done_d = 1'b1;
                end
            end
            SHIFT_OUT: begin
                // A new frame aborts readout; clearing out_q also forces sdo low.
                if (load_rise) begin
                    sr_d   = '0;
                    cnt_d  = '0;
                    out_d  = '0;
                    done_d = 1'b0;
                end else if (sck_rise) begin
                    out_d  = {out_q[126:0], 1'b0};
                    ocnt_d = ocnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ocnt_q  <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            dir_q   <= 1'b0;
            in_q    <= '0;
            key_q   <= '0;
`ifdef AES_SPI_FRAMECHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ocnt_q  <= ocnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            dir_q   <= dir_d;
            in_q    <= in_d;
            key_q   <= key_d;
`ifdef AES_SPI_FRAMECHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign sdo        = out_q[127];
    assign done       = done_q;
    assign core_start = start_q;
    assign core_dir   = dir_q;
    assign core_in    = in_q;
    assign core_key   = key_q;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Directed bench: K=128/INV=2 instance for the main flows, K=256/INV=0 instance for FIPS C.3.
module tb_aes_spi_frontend;

    localparam logic [127:0] PT   = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] KEY  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] CT   = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] PT3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic sdi = 1'b0;
    logic load_a = 1'b0;
    logic load_b = 1'b0;

    logic         sdo_a, done_a, start_a, dir_a;
    logic [127:0] in_a, key_a;
    logic [127:0] cout_a = '0;
    logic         cdone_a = 1'b0;

    logic         sdo_b, done_b, start_b, dir_b;
    logic [127:0] in_b;
    logic [255:0] key_b;
    logic [127:0] cout_b = '0;
    logic         cdone_b = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int start_cnt_a = 0;
    int start_cnt_b = 0;
    int exp_start_a = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_a) start_cnt_a <= start_cnt_a + 1;
        if (start_b) start_cnt_b <= start_cnt_b + 1;
    end

`ifdef AES_SPI_FRAMECHK_EN
    logic ferr_a, ferr_b;
    int   ferr_cnt_a = 0;
    always @(posedge clk) if (ferr_a) ferr_cnt_a <= ferr_cnt_a + 1;
`endif

    aes_spi_frontend #(.K(128), .INV(2)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sdi        (sdi),
        .load       (load_a),
        .sdo        (sdo_a),
        .done       (done_a),
        .core_start (start_a),
        .core_dir   (dir_a),
        .core_in    (in_a),
        .core_key   (key_a),
        .core_out   (cout_a),
        .core_done  (cdone_a)
`ifdef AES_SPI_FRAMECHK_EN
        ,
        .frame_err  (ferr_a)
`endif
    );

    aes_spi_frontend #(.K(256), .INV(0)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sdi        (sdi),
        .load       (load_b),
        .sdo        (sdo_b),
        .done       (done_b),
        .core_start (start_b),
        .core_dir   (dir_b),
        .core_in    (in_b),
        .core_key   (key_b),
        .core_out   (cout_b),
        .core_done  (cdone_b)
`ifdef AES_SPI_FRAMECHK_EN
        ,
        .frame_err  (ferr_b)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_load(input int which, input logic v);
        if (which == 0) load_a = v;
        else load_b = v;
    endtask

    task automatic sck_pulse(input logic b);
        sdi = b;
        wait_clk(4);
        sck = 1'b1;
        wait_clk(4);
        sck = 1'b0;
    endtask

    task automatic frame_bits(input logic [383:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) sck_pulse(data[i]);
    endtask

    task automatic frame_end(input int which);
        wait_clk(4);
        set_load(which, 1'b0);
        wait_clk(8);
    endtask

    task automatic send_frame(input int which, input logic [383:0] data, input int nbits);
        set_load(which, 1'b1);
        wait_clk(4);
        frame_bits(data, nbits);
        frame_end(which);
        $display("frame dut%0d bits=%0d", which, nbits);
    endtask

    task automatic core_reply(input int which, input logic [127:0] v);
        if (which == 0) begin
            cout_a = v; cdone_a = 1'b1; wait_clk(1); cdone_a = 1'b0;
        end else begin
            cout_b = v; cdone_b = 1'b1; wait_clk(1); cdone_b = 1'b0;
        end
        wait_clk(3);
        $display("core_done dut%0d result=%h", which, v);
    endtask

    task automatic read_out(input int which, input int n, output logic [127:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[126:0], (which == 0) ? sdo_a : sdo_b};
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
            wait_clk(4);
        end
        $display("readout dut%0d bits=%0d value=%h", which, n, v);
    endtask

    logic [383:0] fa, fb, f3;
    logic [127:0] rd;

    initial begin
        fa = {8'h00, PT, KEY};
        fb = {8'hFF, CT, KEY};
        f3 = {PT3, KEY3};

        // Reset state
        wait_clk(3);
        chk("rst_sdo", sdo_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_start", start_a, 0);
        chk("rst_dir", dir_a, 0);
        chk("rst_in", in_a, 0);
        chk("rst_key", key_a, 0);
        reset = 1'b0;
        wait_clk(4);

        // Encrypt frame and full readout
        send_frame(0, fa, 264);
        exp_start_a++;
        chk("a_in", in_a, PT);
        chk("a_key", key_a, KEY);
        chk("a_dir", dir_a, 0);
        chk("a_start_cnt", start_cnt_a, exp_start_a);
        core_reply(0, CT);
        chk("a_done", done_a, 1);
        read_out(0, 128, rd);
        chk("a_read", rd, CT);
        chk("a_done_after", done_a, 1);
        chk("a_sdo_after", sdo_a, 0);

        // Decrypt frame, partial readout, abort with a new frame
        send_frame(0, fb, 264);
        exp_start_a++;
        chk("b_dir", dir_a, 1);
        chk("b_in", in_a, CT);
        chk("b_key", key_a, KEY);
        chk("b_start_cnt", start_cnt_a, exp_start_a);
        core_reply(0, PT);
        read_out(0, 40, rd);
        chk("b_read40", rd[39:0], PT[127:88]);
        load_a = 1'b1;
        wait_clk(4);
        chk("abort_done", done_a, 0);
        frame_bits(fa, 264);
        frame_end(0);
        exp_start_a++;
        chk("abort_in", in_a, PT);
        chk("abort_dir", dir_a, 0);
        chk("abort_start_cnt", start_cnt_a, exp_start_a);
        core_reply(0, CT);
        read_out(0, 128, rd);
        chk("abort_read", rd, CT);

        // Short 200-bit frame
        send_frame(0, fa >> 64, 200);
`ifdef AES_SPI_FRAMECHK_EN
        chk("short_ferr_cnt", ferr_cnt_a, 1);
        chk("short_start_cnt", start_cnt_a, exp_start_a);
`else
        exp_start_a++;
        chk("short_start_cnt", start_cnt_a, exp_start_a);
        chk("short_dir", dir_a, 0);
`endif
        chk("short_done", done_a, 0);

        // Reset after 100 input bits
        load_a = 1'b1;
        wait_clk(4);
        frame_bits(fa >> 164, 100);
        load_a = 1'b0;
        reset = 1'b1;
        wait_clk(2);
        chk("mid_rst_in", in_a, 0);
        chk("mid_rst_key", key_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_sdo", sdo_a, 0);
        chk("mid_rst_start_cnt", start_cnt_a, exp_start_a);
        reset = 1'b0;
        wait_clk(4);
        send_frame(0, fb, 264);
        exp_start_a++;
        chk("post_rst_in", in_a, CT);
        chk("post_rst_dir", dir_a, 1);

        // sck activity while waiting on the core is ignored
        for (int i = 0; i < 6; i++) sck_pulse(1'($urandom_range(1, 0)));
        wait_clk(4);
        chk("wait_in", in_a, CT);
        chk("wait_key", key_a, KEY);
        chk("wait_dir", dir_a, 1);
        chk("wait_done", done_a, 0);
        chk("wait_start_cnt", start_cnt_a, exp_start_a);
        core_reply(0, PT);
        read_out(0, 128, rd);
        chk("post_rst_read", rd, PT);

        // core_done outside WAIT_CORE is ignored
        core_reply(0, CT);
        chk("stray_done", done_a, 1);
        chk("stray_sdo", sdo_a, 0);

        // K=256 encrypt-only instance
        send_frame(1, f3, 384);
        chk("k256_dir", dir_b, 0);
        chk("k256_key", key_b, KEY3);
        chk("k256_in", in_b, PT3);
        chk("k256_start_cnt", start_cnt_b, 1);
        core_reply(1, CT3);
        chk("k256_done", done_b, 1);
        read_out(1, 128, rd);
        chk("k256_read", rd, CT3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_spi_frontend.md
Name: aes_spi_frontend

Overview:
SPI slave front-end of the AES accelerator. Sits between the external SPI pins (sck/sdi/sdo/load/done) and the AES round core.
- Deserialises {dir byte, plaintext, key} MSB-first into parallel core inputs.
- Pulses the core start.
- Captures the 128-bit core result and serialises it back out on sdo.
- All logic runs in the clk domain; sck and load are oversampled.

Parameters:
- K, 128, key width in bits (128/192/256).
- INV, 2, direction mode: 0 = encrypt only, 1 = decrypt only, 2 = runtime-selected by a leading direction byte.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sck  input  1  SPI serial clock (asynchronous to clk).
- sdi  input  1  SPI serial data in.
- load  input  1  frame enable: high while shifting input, falling edge starts the core.
- sdo  output  1  SPI serial data out, MSB of result first.
- done  output  1  result valid and ready to shift out.
- core_start  output  1  one-cycle start pulse to the AES core.
- core_dir  output  1  0 = encrypt, 1 = decrypt.
- core_in  output  128  plaintext/ciphertext block to the core.
- core_key  output  K  key to the core.
- core_out  input  128  core result.
- core_done  input  1  single-cycle pulse when core_out is valid.

Behaviour:
- Reset values: sdo=0, done=0, core_start=0, core_dir=0, core_in=0, core_key=0. All registers and the FSM clear asynchronously.
- Frame length: TOTAL = K+128, plus 8 when INV==2.
- Synchronisation: sck and load each pass a 2-flop synchroniser plus edge detector.
  - sck high and low phases must each be at least 3 clk periods.
  - Edge-to-action latency is 3 clk.
- States: IDLE, SHIFT_IN, WAIT_CORE, SHIFT_OUT.
- IDLE:
  - Synced load rising -> SHIFT_IN; clear the bit counter and done.
- SHIFT_IN:
  - Each synced sck rising edge shifts sdi into the LSB of a TOTAL-bit register; the counter saturates at TOTAL.
  - More than TOTAL bits: only the last TOTAL bits are retained.
  - Synced load falling -> latch core_key = sr[K-1:0] and core_in = sr[K+127:K].
  - core_dir: INV==0 -> 0; INV==1 -> 1; INV==2 -> 1 only if the top byte is 8'hFF, else 0.
  - Pulse core_start for exactly 1 cycle on the following clk, then -> WAIT_CORE.
- WAIT_CORE:
  - sck edges and load edges are ignored.
  - core_done -> capture core_out into the 128-bit out register; done=1 on the next clk; sdo = out[127]; -> SHIFT_OUT.
- SHIFT_OUT:
  - Each synced sck rising edge shifts the out register left and fills 0.
  - Master samples sdo at its own sck rise, before the synced shift, so it sees the current bit.
  - After 128 shifts -> IDLE with done held at 1 and sdo=0.
  - Synced load rising aborts readout: done=0, -> SHIFT_IN.
- done clears only on the next load rising edge or on reset.
- core_done outside WAIT_CORE is ignored.
- Simultaneous events: load falling and sck rising in the same cycle -> the sck shift is applied first, then the latch.
- Reset mid-operation: returns to IDLE immediately; no core_start is issued.

Optional Feature:
- Macro: AES_SPI_FRAMECHK_EN.
- With it defined:
  - Adds output frame_err (1 bit, reset 0).
  - On load falling, if the bit count is not equal to TOTAL: no core_start, frame_err pulses 1 cycle, -> IDLE.
  - With INV==2, a direction byte other than 8'h00/8'hFF also triggers frame_err.
- Without it: core_start fires regardless of the bit count, and any non-FF direction byte selects encrypt.

Decomposition:
- aes_pkg:
  - state enum (IDLE/SHIFT_IN/WAIT_CORE/SHIFT_OUT).
  - DIR_ENC=8'h00, DIR_DEC=8'hFF.
  - function total_bits(K, INV).
- Sub-module sync_edge: 2-flop synchroniser with rise/fall pulse outputs, with clk and reset. Instantiated for sck and load.

Test Plan:
- K=128, INV=2, dir 00, pt 3243F6A8885A308D313198A2E0370734, key 2B7E151628AED2A6ABF7158809CF4F3C -> core_in/core_key match, core_dir=0, exactly one core_start pulse. Model core_done with 3925841D02DC09FBDC118597196A0B32 -> done=1, 128 sck reads return that value.
- Same frame with dir FF, ciphertext 3925...0B32 as data -> core_dir=1, core_in=3925841D02DC09FBDC118597196A0B32.
- AES_SPI_FRAMECHK_EN, 200-bit frame -> frame_err pulses 1 cycle, no core_start, state IDLE. Without the macro -> core_start is issued.
- Readout 40 bits, then load raised -> done=0 within 4 clk; a new full frame completes correctly.
- Reset asserted after 100 input bits -> all outputs 0. A subsequent full frame is correct, and sck toggling in WAIT_CORE does not change any registers.
- K=256, INV=0, FIPS C.3 vector (TOTAL=384) -> core_dir=0, core_key=000102...1e1f, readout 8ea2b7ca516745bfeafc49904b496089.
